replacement_sequencer: RTL and testbench

- Miss-handling controller that sequences the replacement controller, tag/dirty array and memory interface for one L1 miss at a time.
- On an accepted miss it:
  - presents the set index to the replacement controller and captures the chosen victim way;
  - writes the victim back if it is dirty;
  - requests the line fill;
  - pulses the LRU update for the refilled way, then reports completion.
- Sits between the L1 cache core FSM (requester) and replacement_controller, the tag array and the main-memory port.

---
 rtl/replacement_sequencer_pkg.sv | 25 ++
 rtl/replacement_sequencer_if.sv | 38 +++
 rtl/replacement_sequencer_onehot_to_binary.sv | 21 ++
 rtl/replacement_sequencer.sv | 108 ++++++++++
 tb/tb_replacement_sequencer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/replacement_sequencer_pkg.sv
// Shared definitions for the L1 miss replacement sequencer: state encoding,
// log2 helper and statistics counter width.
package replacement_sequencer_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        WB     = 3'd2,
        FILL   = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

    // Ceiling log2; exact for the power-of-two way counts used here.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/replacement_sequencer_if.sv
// Miss, replacement-controller, tag-array and memory handshake bundle of the
// replacement sequencer. The slave modport is the sequencer side.
interface replacement_sequencer_if
    import replacement_sequencer_pkg::*;
#(
    parameter int NUMBER_OF_WAYS = 8,
    parameter int INDEX_BITS     = 8
);
    localparam int WAY_BITS = log2(NUMBER_OF_WAYS);

    logic                      miss_req;
    logic [INDEX_BITS-1:0]     miss_index;
    logic                      miss_ready;
    logic [INDEX_BITS-1:0]     repl_index;
    logic [NUMBER_OF_WAYS-1:0] selected_way;
    logic [NUMBER_OF_WAYS-1:0] way_dirty;
    logic                      wb_req;
    logic                      wb_ack;
    logic                      fill_req;
    logic                      fill_ack;
    logic [WAY_BITS-1:0]       victim_way;
    logic [WAY_BITS-1:0]       lru_access;
    logic                      lru_access_valid;
    logic                      done;

    modport slave (
        input  miss_req, miss_index, selected_way, way_dirty, wb_ack, fill_ack,
        output miss_ready, repl_index, wb_req, fill_req, victim_way,
               lru_access, lru_access_valid, done
    );

    modport master (
        output miss_req, miss_index, selected_way, way_dirty, wb_ack, fill_ack,
        input  miss_ready, repl_index, wb_req, fill_req, victim_way,
               lru_access, lru_access_valid, done
    );

endinterface

// File: rtl/replacement_sequencer_onehot_to_binary.sv
// Lowest-set-bit priority encoder; an all-zero input encodes to 0.
// Shared with empty_way_select.
module onehot_to_binary
    import replacement_sequencer_pkg::*;
#(
    parameter int NUMBER_OF_WAYS = 8,
    localparam int WAY_BITS      = log2(NUMBER_OF_WAYS)
) (
    input  logic [NUMBER_OF_WAYS-1:0] onehot,
    output logic [WAY_BITS-1:0]       binary
);

    // Scan downward so the lowest set bit is the last assignment to win.
    always_comb begin
        binary = '0;
        for (int i = NUMBER_OF_WAYS - 1; i >= 0; i--) begin
            if (onehot[i]) binary = WAY_BITS'(i);
        end
    end

endmodule

// File: rtl/replacement_sequencer.sv
// Services one L1 miss at a time: victim select, optional writeback, fill,
// LRU update. Define REPL_SEQ_STATS_EN to add miss_count / wb_count outputs.
//
// state  | meaning
// IDLE   | miss_ready high, waiting for miss_req
// SELECT | repl_index presented, victim and dirty bit sampled at end of cycle
// WB     | wb_req held until wb_ack
// FILL   | fill_req held until fill_ack
// DONE   | one-cycle done / lru_access_valid pulse
module replacement_sequencer
    import replacement_sequencer_pkg::*;
#(
    parameter int NUMBER_OF_WAYS = 8,
    parameter int INDEX_BITS     = 8,
    localparam int WAY_BITS      = log2(NUMBER_OF_WAYS)
) (
    input  logic                  clock,
    input  logic                  reset,
`ifdef REPL_SEQ_STATS_EN
    output logic [CNT_W-1:0]      miss_count,
    output logic [CNT_W-1:0]      wb_count,
`endif
    replacement_sequencer_if.slave bus
);

    seq_state_t          state;
    logic [WAY_BITS-1:0] victim_enc;

    onehot_to_binary #(
        .NUMBER_OF_WAYS (NUMBER_OF_WAYS)
    ) u_victim_enc (
        .onehot (bus.selected_way),
        .binary (victim_enc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state                <= IDLE;
            bus.miss_ready       <= 1'b1;
            bus.repl_index       <= '0;
            bus.wb_req           <= 1'b0;
            bus.fill_req         <= 1'b0;
            bus.victim_way       <= '0;
            bus.lru_access       <= '0;
            bus.lru_access_valid <= 1'b0;
            bus.done             <= 1'b0;
`ifdef REPL_SEQ_STATS_EN
            miss_count           <= '0;
            wb_count             <= '0;
`endif
        end else begin
            bus.lru_access_valid <= 1'b0;
            bus.done             <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.miss_req) begin
                        bus.repl_index <= bus.miss_index;
                        bus.miss_ready <= 1'b0;
                        state          <= SELECT;
`ifdef REPL_SEQ_STATS_EN
                        miss_count     <= miss_count + 1'b1;
`endif
                    end
                end
                SELECT: begin
                    bus.victim_way <= victim_enc;
                    if (bus.way_dirty[victim_enc]) begin
                        bus.wb_req <= 1'b1;
                        state      <= WB;
`ifdef REPL_SEQ_STATS_EN
                        wb_count   <= wb_count + 1'b1;
`endif
                    end else begin
                        bus.fill_req <= 1'b1;
                        state        <= FILL;
                    end
                end
                WB: begin
                    if (bus.wb_ack) begin
                        bus.wb_req   <= 1'b0;
                        bus.fill_req <= 1'b1;
                        state        <= FILL;
                    end
                end
                FILL: begin
                    if (bus.fill_ack) begin
                        bus.fill_req         <= 1'b0;
                        bus.lru_access       <= bus.victim_way;
                        bus.lru_access_valid <= 1'b1;
                        bus.done             <= 1'b1;
                        state                <= DONE;
                    end
                end
                DONE: begin
                    bus.miss_ready <= 1'b1;
                    state          <= IDLE;
                end
                default: begin
                    bus.miss_ready <= 1'b1;
                    bus.wb_req     <= 1'b0;
                    bus.fill_req   <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_replacement_sequencer.sv
// Self-checking bench for replacement_sequencer: vector table, randomized
// misses against a transaction-level model, and hand-written corner cases.
module tb_replacement_sequencer;

    logic clock;
    logic reset;
    int   tests;
    int   failed;
    int   exp_miss;
    int   exp_wbc;

`ifdef REPL_SEQ_STATS_EN
    logic [31:0] miss_count;
    logic [31:0] wb_count;
`endif

    replacement_sequencer_if #(.NUMBER_OF_WAYS(8), .INDEX_BITS(8)) bus ();

    replacement_sequencer #(
        .NUMBER_OF_WAYS (8),
        .INDEX_BITS     (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
`ifdef REPL_SEQ_STATS_EN
        .miss_count (miss_count),
        .wb_count   (wb_count),
`endif
        .bus        (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] idx;
        logic [7:0] sel;
        logic [7:0] dirty;
        int         wb_lat;
        int         fill_lat;
        bit         spur;
        logic [2:0] exp_vic;
        bit         exp_wb;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Victim rule: isolate the lowest set bit arithmetically, then take its position.
    function automatic logic [2:0] model_victim(input logic [7:0] s);
        logic [7:0] iso;
        int         v;
        iso = s & (~s + 8'd1);
        v   = 0;
        while (iso > 8'd1) begin
            iso = iso >> 1;
            v++;
        end
        return 3'(v);
    endfunction

    task automatic chk_stats();
`ifdef REPL_SEQ_STATS_EN
        chk("miss_count", miss_count, 32'(exp_miss));
        chk("wb_count", wb_count, 32'(exp_wbc));
`endif
    endtask

    task automatic run_miss(input logic [7:0] idx, input logic [7:0] sel, input logic [7:0] dirty,
                            input int wb_lat, input int fill_lat, input bit hold, input bit spur,
                            input logic [2:0] exp_vic, input bit exp_wb);
        chk("idle_ready", 32'(bus.miss_ready), 1);
        bus.miss_req     = 1'b1;
        bus.miss_index   = idx;
        bus.selected_way = 8'($urandom);
        bus.way_dirty    = 8'($urandom);
        step();
        exp_miss++;
        if (hold) bus.miss_index = ~idx;
        else      bus.miss_req   = 1'b0;
        bus.selected_way = sel;
        bus.way_dirty    = dirty;
        chk("select_ready", 32'(bus.miss_ready), 0);
        chk("repl_index", 32'(bus.repl_index), 32'(idx));
        step();
        bus.selected_way = 8'($urandom);
        bus.way_dirty    = 8'($urandom);
        chk("victim_way", 32'(bus.victim_way), 32'(exp_vic));
        if (exp_wb) begin
            exp_wbc++;
            for (int k = 0; k <= wb_lat; k++) begin
                chk("wb_req_held", 32'(bus.wb_req), 1);
                chk("wb_fill_low", 32'(bus.fill_req), 0);
                chk("wb_no_done", 32'(bus.done), 0);
                chk("wb_repl_index", 32'(bus.repl_index), 32'(idx));
                if (k == wb_lat) bus.wb_ack = 1'b1;
                else if (spur)   bus.fill_ack = 1'b1;
                step();
                bus.wb_ack   = 1'b0;
                bus.fill_ack = 1'b0;
            end
        end
        chk("wb_req_low", 32'(bus.wb_req), 0);
        for (int k = 0; k <= fill_lat; k++) begin
            chk("fill_req_held", 32'(bus.fill_req), 1);
            chk("fill_wb_low", 32'(bus.wb_req), 0);
            chk("fill_no_done", 32'(bus.done), 0);
            chk("fill_ready_low", 32'(bus.miss_ready), 0);
            if (k == fill_lat) bus.fill_ack = 1'b1;
            else if (spur)     bus.wb_ack = 1'b1;
            step();
            bus.wb_ack   = 1'b0;
            bus.fill_ack = 1'b0;
        end
        chk("done_pulse", 32'(bus.done), 1);
        chk("lru_valid", 32'(bus.lru_access_valid), 1);
        chk("lru_access", 32'(bus.lru_access), 32'(exp_vic));
        chk("done_fill_low", 32'(bus.fill_req), 0);
        chk("done_ready_low", 32'(bus.miss_ready), 0);
        step();
        chk("done_cleared", 32'(bus.done), 0);
        chk("lru_valid_cleared", 32'(bus.lru_access_valid), 0);
        chk("ready_after_done", 32'(bus.miss_ready), 1);
        chk_stats();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset    = 1'b0;
        exp_miss = 0;
        exp_wbc  = 0;
    endtask

    initial begin
        logic [7:0] r_idx, r_sel, r_dirty;
        logic [2:0] r_vic;
        tests    = 0;
        failed   = 0;
        exp_miss = 0;
        exp_wbc  = 0;
        reset            = 1'b1;
        bus.miss_req     = 1'b0;
        bus.miss_index   = '0;
        bus.selected_way = '0;
        bus.way_dirty    = '0;
        bus.wb_ack       = 1'b0;
        bus.fill_ack     = 1'b0;

        vecs[0] = '{8'h2A, 8'b0000_0100, 8'h00, 0, 5, 1'b0, 3'd2, 1'b0};
        vecs[1] = '{8'h55, 8'b1000_0000, 8'h80, 2, 1, 1'b0, 3'd7, 1'b1};
        vecs[2] = '{8'h01, 8'b0000_0000, 8'h01, 0, 0, 1'b0, 3'd0, 1'b1};
        vecs[3] = '{8'h7F, 8'b0011_0000, 8'h20, 0, 2, 1'b0, 3'd4, 1'b0};
        vecs[4] = '{8'hC3, 8'b0011_0000, 8'h10, 3, 2, 1'b1, 3'd4, 1'b1};
        vecs[5] = '{8'hFF, 8'b0000_0010, 8'hFD, 1, 0, 1'b1, 3'd1, 1'b0};

        do_reset();
        chk("rst_ready", 32'(bus.miss_ready), 1);
        chk("rst_wb_req", 32'(bus.wb_req), 0);
        chk("rst_fill_req", 32'(bus.fill_req), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_lru_valid", 32'(bus.lru_access_valid), 0);
        chk("rst_repl_index", 32'(bus.repl_index), 0);
        chk("rst_victim", 32'(bus.victim_way), 0);
        chk("rst_lru_access", 32'(bus.lru_access), 0);
        chk_stats();

        // Stray acks while idle must not start anything.
        bus.wb_ack   = 1'b1;
        bus.fill_ack = 1'b1;
        step();
        bus.wb_ack   = 1'b0;
        bus.fill_ack = 1'b0;
        step();
        chk("idle_ack_ready", 32'(bus.miss_ready), 1);
        chk("idle_ack_wb", 32'(bus.wb_req), 0);
        chk("idle_ack_fill", 32'(bus.fill_req), 0);
        chk("idle_ack_done", 32'(bus.done), 0);

        for (int i = 0; i < 6; i++) begin
            run_miss(vecs[i].idx, vecs[i].sel, vecs[i].dirty, vecs[i].wb_lat,
                     vecs[i].fill_lat, 1'b0, vecs[i].spur, vecs[i].exp_vic, vecs[i].exp_wb);
        end

        // Dirty miss as the first after reset: both counters read 1.
        do_reset();
        run_miss(8'h10, 8'b1000_0000, 8'h80, 2, 0, 1'b0, 1'b0, 3'd7, 1'b1);

        // miss_req held through a whole service: second miss accepted at M+2.
        run_miss(8'h3C, 8'b0000_1000, 8'h00, 0, 1, 1'b1, 1'b0, 3'd3, 1'b0);
        run_miss(8'hA5, 8'b0100_0000, 8'h40, 1, 1, 1'b0, 1'b0, 3'd6, 1'b1);

        for (int n = 0; n < 25; n++) begin
            r_idx   = 8'($urandom);
            r_sel   = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            r_dirty = 8'($urandom);
            r_vic   = model_victim(r_sel);
            run_miss(r_idx, r_sel, r_dirty, $urandom_range(0, 4), $urandom_range(0, 4),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r_vic, r_dirty[r_vic]);
        end
        bus.miss_req = 1'b0;
        step();

        // Reset while waiting for the fill.
        bus.miss_req   = 1'b1;
        bus.miss_index = 8'h66;
        bus.selected_way = 8'h01;
        bus.way_dirty    = 8'h00;
        step();
        bus.miss_req = 1'b0;
        step();
        step();
        chk("pre_reset_fill", 32'(bus.fill_req), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_miss = 0;
        exp_wbc  = 0;
        chk("mid_rst_fill", 32'(bus.fill_req), 0);
        chk("mid_rst_wb", 32'(bus.wb_req), 0);
        chk("mid_rst_ready", 32'(bus.miss_ready), 1);
        chk("mid_rst_done", 32'(bus.done), 0);
        chk_stats();
        bus.fill_ack = 1'b1;
        step();
        bus.fill_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("post_rst_no_done", 32'(bus.done), 0);
            chk("post_rst_ready", 32'(bus.miss_ready), 1);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
